// File: rtl/cell_mem_arbiter_if.sv
// Cell RAM arbiter bus: renderer, editor, engine and RAM-side signals.
// ARB_STATS_EN adds the eng_stall_cnt statistics output.
interface cell_mem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          candraw;
  logic [AW-1:0] rnd_addr;
  logic [DW-1:0] rnd_data;
  logic          edit_req;
  logic [AW-1:0] edit_addr;
  logic [2:0]    edit_bit;
  logic          edit_busy;
  logic          eng_req;
  logic          eng_we;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_wdata;
  logic          eng_gnt;
  logic          eng_rvalid;
  logic [DW-1:0] eng_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0]   eng_stall_cnt;

  modport slave (
    input  candraw, rnd_addr, edit_req, edit_addr, edit_bit,
           eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
    output rnd_data, edit_busy, eng_gnt, eng_rvalid, eng_rdata,
           mem_addr, mem_we, mem_wdata, eng_stall_cnt
  );
  modport master (
    output candraw, rnd_addr, edit_req, edit_addr, edit_bit,
           eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
    input  rnd_data, edit_busy, eng_gnt, eng_rvalid, eng_rdata,
           mem_addr, mem_we, mem_wdata, eng_stall_cnt
  );
`else
  modport slave (
    input  candraw, rnd_addr, edit_req, edit_addr, edit_bit,
           eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
    output rnd_data, edit_busy, eng_gnt, eng_rvalid, eng_rdata,
           mem_addr, mem_we, mem_wdata
  );
  modport master (
    output candraw, rnd_addr, edit_req, edit_addr, edit_bit,
           eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
    input  rnd_data, edit_busy, eng_gnt, eng_rvalid, eng_rdata,
           mem_addr, mem_we, mem_wdata
  );
`endif
endinterface

// File: rtl/cell_mem_arbiter.sv
// Cell RAM arbiter: renderer > editor (bit-toggle RMW) > life engine.
// Optional macro ARB_STATS_EN adds a saturating engine stall counter.
module cell_mem_arbiter #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input logic               clk,
  input logic               rst,
  cell_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ED_RD, ED_CAP, ED_WR} state_t;

  state_t        state;
  logic [AW-1:0] ed_addr;
  logic [2:0]    ed_bit;
  logic [DW-1:0] ed_buf;
  logic          busy_q;
  logic          rvalid_q;

  logic          gnt;
  logic          rd_slot;
  logic          wr_slot;
  logic [DW-1:0] ed_mask;

  // Engine only gets the RAM when the renderer is off it and no edit is in flight;
  // nothing is granted or written while reset is asserted.
  assign gnt     = bus.eng_req & ~bus.candraw & (state == IDLE) & ~rst;
  assign rd_slot = (state == ED_RD) & ~bus.candraw;
  assign wr_slot = (state == ED_WR) & ~bus.candraw & ~rst;
  assign ed_mask = DW'(1) << ed_bit;

  // RAM port mux: default owner is the renderer address, read-only.
  always_comb begin
    bus.mem_addr  = bus.rnd_addr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (gnt) begin
      bus.mem_addr  = bus.eng_addr;
      bus.mem_we    = bus.eng_we;
      bus.mem_wdata = bus.eng_wdata;
    end else if (rd_slot) begin
      bus.mem_addr  = ed_addr;
    end else if (wr_slot) begin
      bus.mem_addr  = ed_addr;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = ed_buf ^ ed_mask;
    end
  end

  assign bus.rnd_data   = bus.mem_rdata;
  assign bus.eng_rdata  = bus.mem_rdata;
  assign bus.eng_gnt    = gnt;
  assign bus.eng_rvalid = rvalid_q;
  assign bus.edit_busy  = busy_q;

  // Editor RMW sequencer plus registered engine read-valid; edits arriving
  // while busy are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      ed_addr  <= '0;
      ed_bit   <= '0;
      ed_buf   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= gnt & ~bus.eng_we;
      case (state)
        IDLE: if (bus.edit_req) begin
          ed_addr <= bus.edit_addr;
          ed_bit  <= bus.edit_bit;
          state   <= ED_RD;
          busy_q  <= 1'b1;
        end
        ED_RD: if (!bus.candraw) state <= ED_CAP;
        ED_CAP: begin
          ed_buf <= bus.mem_rdata;
          state  <= ED_WR;
        end
        ED_WR: if (!bus.candraw) begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt;

  // Count cycles the engine waits with a pending request; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                                         stall_cnt <= '0;
    else if (bus.eng_req && !gnt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

  assign bus.eng_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Randomised scoreboard bench for cell_mem_arbiter (ARB_STATS_EN optional).
module tb_cell_mem_arbiter;
  localparam int AW   = 11;
  localparam int DW   = 8;
  localparam int NCYC = 3000;
  localparam int NARR = NCYC + 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_en = 1'b1;
  always #5 clk = ~clk;

  cell_mem_arbiter_if #(.AW(AW), .DW(DW)) arb ();
  cell_mem_arbiter #(.AW(AW), .DW(DW)) u_dut (.clk(clk), .rst(rst), .bus(arb.slave));

  int tests = 0;
  int fails = 0;

  logic [7:0] tb_mem  [0:2047];
  logic [7:0] ref_mem [0:2047];
  logic       cd_arr  [0:NARR-1];

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 97) ^ (i >> 4) ^ 8'h5A);
  endfunction

  // Behavioural synchronous RAM (read-before-write, one cycle latency).
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 2048; i++) tb_mem[i] <= init_val(i);
    end else if (arb.mem_we) begin
      tb_mem[arb.mem_addr] <= arb.mem_wdata;
    end
    arb.mem_rdata <= tb_mem[arb.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       gnt;
    logic       we;
    logic       busy;
    logic       cd;
    logic [7:0] rnd_exp;
    int         stall;
  } cyc_t;

  cyc_t       cyc_q[$];
  logic [7:0] rd_q[$];
  cyc_t       prv = '{default: 0};

  // Monitor: one expectation record per scoreboarded cycle.
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      cyc_t cur;
      logic [7:0] e;
      cur = cyc_q.pop_front();
      chk("eng_gnt", 32'(arb.eng_gnt), 32'(cur.gnt));
      chk("edit_busy", 32'(arb.edit_busy), 32'(cur.busy));
      if (cur.cd) chk("mem_we_candraw", 32'(arb.mem_we), 32'd0);
      chk("eng_rvalid", 32'(arb.eng_rvalid), 32'(prv.gnt && !prv.we));
      if (arb.eng_rvalid) begin
        if (rd_q.size() == 0) chk("eng_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          e = rd_q.pop_front();
          chk("eng_rdata", 32'(arb.eng_rdata), 32'(e));
        end
      end
      if (prv.cd) chk("rnd_data", 32'(arb.rnd_data), 32'(prv.rnd_exp));
`ifdef ARB_STATS_EN
      chk("eng_stall_cnt", 32'(arb.eng_stall_cnt), 32'(cur.stall));
`endif
      prv = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return AW'(11'h7FF);
      1:       return AW'(11'h100);
      2:       return AW'($urandom_range(0, 2047));
      default: return AW'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic int next_free(input int from);
    for (int i = from; i < NARR; i++) if (!cd_arr[i]) return i;
    return NARR;
  endfunction

  initial begin
    int acc, rdc, wr, stall_n, burst;
    logic [AW-1:0] ed_a, pa;
    logic [7:0] ed_m, pd;
    logic pend, pwe, gnt, busy, ereq;
    cyc_t rec;

    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
    arb.candraw = 0; arb.rnd_addr = '0; arb.edit_req = 0; arb.edit_addr = '0;
    arb.edit_bit = '0; arb.eng_req = 0; arb.eng_we = 0; arb.eng_addr = '0; arb.eng_wdata = '0;

    // Reset and reset state.
    repeat (3) step();
    rst = 0; init_en = 0; arb.rnd_addr = AW'(5);
    @(negedge clk);
    chk("rst_edit_busy", 32'(arb.edit_busy), 32'd0);
    chk("rst_eng_rvalid", 32'(arb.eng_rvalid), 32'd0);
    chk("rst_mem_we", 32'(arb.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(arb.mem_addr), 32'd5);
`ifdef ARB_STATS_EN
    chk("rst_stall_cnt", 32'(arb.eng_stall_cnt), 32'd0);
`endif

    // Renderer owns the RAM, engine write request must be refused.
    step();
    arb.candraw = 1; arb.eng_req = 1; arb.eng_we = 1; arb.eng_addr = AW'(5); arb.eng_wdata = 8'hFF;
    @(negedge clk);
    chk("rnd_eng_gnt", 32'(arb.eng_gnt), 32'd0);
    chk("rnd_mem_we", 32'(arb.mem_we), 32'd0);
    step();
    arb.eng_req = 0;
    @(negedge clk);
    chk("rnd_pass_data", 32'(arb.rnd_data), 32'(ref_mem[5]));
    chk("rnd_mem_we2", 32'(arb.mem_we), 32'd0);

    // Reset while the edit is capturing: edit abandoned.
    step();
    arb.candraw = 0; arb.edit_req = 1; arb.edit_addr = AW'(11'h7FF); arb.edit_bit = 3'd0;
    step();
    arb.edit_req = 0;
    @(negedge clk);
    chk("edit_busy_rd", 32'(arb.edit_busy), 32'd1);
    step();
    rst = 1;
    @(negedge clk);
    chk("rst_cap_mem_we", 32'(arb.mem_we), 32'd0);
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_cap_busy", 32'(arb.edit_busy), 32'd0);
    chk("rst_cap_rvalid", 32'(arb.eng_rvalid), 32'd0);
    chk("rst_cap_mem_we2", 32'(arb.mem_we), 32'd0);

    // Reset landing on the write slot: no write in the reset cycle.
    step();
    arb.edit_req = 1;
    step();
    arb.edit_req = 0;
    step();
    step();
    rst = 1;
    @(negedge clk);
    chk("rst_wr_mem_we", 32'(arb.mem_we), 32'd0);
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_wr_busy", 32'(arb.edit_busy), 32'd0);
    step();
    step();
    chk("rst_ram_untouched", 32'(tb_mem[11'h7FF]), 32'(ref_mem[11'h7FF]));

    // Candraw schedule: random bursts, quiet tail so every edit completes.
    burst = 0;
    for (int i = 0; i < NARR; i++) begin
      if (burst == 0 && i < NCYC && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 12);
      cd_arr[i] = (burst > 0);
      if (burst > 0) burst--;
    end

    acc = -1; rdc = -1; wr = -1; stall_n = 0; pend = 0;
    ed_a = '0; ed_m = '0; pa = '0; pd = '0; pwe = 0;
    for (int c = 0; c < NCYC + 40; c++) begin
      step();
      if (!pend && c < NCYC && $urandom_range(0, 1) == 1) begin
        pend = 1; pwe = 1'($urandom_range(0, 1)); pa = pick_addr(); pd = 8'($urandom);
      end
      ereq = (c < NCYC) && ($urandom_range(0, 5) == 0);
      arb.candraw   = cd_arr[c];
      arb.eng_req   = pend;
      arb.eng_we    = pwe;
      arb.eng_addr  = pa;
      arb.eng_wdata = pd;
      arb.edit_req  = ereq;
      arb.edit_addr = pick_addr();
      arb.edit_bit  = 3'($urandom_range(0, 7));
      arb.rnd_addr  = pick_addr();

      busy = (c > acc) && (c <= wr);
      gnt  = pend && !cd_arr[c] && !busy;
      rec.stall = stall_n;
      if (pend && !gnt && stall_n < 65535) stall_n++;
      if (gnt) begin
        if (pwe) ref_mem[pa] = pd;
        else     rd_q.push_back(ref_mem[pa]);
      end
      if (ereq && !busy) begin
        acc  = c;
        rdc  = next_free(c + 1);
        wr   = next_free(rdc + 2);
        ed_a = arb.edit_addr;
        ed_m = 8'(1) << arb.edit_bit;
        ref_mem[ed_a] = ref_mem[ed_a] ^ ed_m;
      end
      rec.gnt = gnt; rec.we = pwe; rec.busy = busy; rec.cd = cd_arr[c];
      rec.rnd_exp = ref_mem[arb.rnd_addr];
      if (c <= wr && arb.rnd_addr == ed_a) rec.rnd_exp = rec.rnd_exp ^ ed_m;
      cyc_q.push_back(rec);
      if (gnt) pend = 0;
    end
    step();
    arb.eng_req = 0; arb.edit_req = 0; arb.candraw = 0;
    repeat (4) step();
    chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("pend_drained", 32'(pend), 32'd0);
    for (int i = 0; i < 2048; i++) chk("ram_final", 32'(tb_mem[i]), 32'(ref_mem[i]));

`ifdef ARB_STATS_EN
    // Saturation and clear of the stall counter.
    arb.candraw = 1; arb.eng_req = 1; arb.eng_we = 0;
    repeat (70000) step();
    @(negedge clk);
    chk("stall_sat", 32'(arb.eng_stall_cnt), 32'hFFFF);
    step();
    rst = 1;
    step();
    rst = 0; arb.eng_req = 0;
    @(negedge clk);
    chk("stall_clr", 32'(arb.eng_stall_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
